// File: rtl/tb_harness_pkg.sv
// Shared types and constants for the test-harness controller.
package tb_harness_pkg;

    // Harness sequencing states.
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CON_W  = 8;
    localparam int unsigned EXIT_W = DATA_W - 1;

    // Default MMIO map of the harness.
    localparam logic [ADDR_W-1:0] DEF_TOHOST_ADDR  = 32'hF000_0000;
    localparam logic [ADDR_W-1:0] DEF_CONSOLE_ADDR = 32'hF000_0004;

    // Value written to tohost that reports a passing run.
    localparam logic [DATA_W-1:0] PASS_CODE = 32'd1;

    // Exit code carried by a tohost write (value shifted right by one).
    function automatic logic [EXIT_W-1:0] exit_of(input logic [DATA_W-1:0] v);
        return v[DATA_W-1:1];
    endfunction

endpackage

// File: rtl/tb_harness_if.sv
// MMIO write channel from the core plus the console byte stream out.
interface tb_harness_if;
    import tb_harness_pkg::*;

    logic              mmio_valid;
    logic              mmio_ready;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wdata;

    logic              con_valid;
    logic              con_ready;
    logic [CON_W-1:0]  con_data;

    // Core / testbench side: issues MMIO writes, consumes console bytes.
    modport master (
        output mmio_valid, mmio_addr, mmio_wdata, con_ready,
        input  mmio_ready, con_valid, con_data
    );

    // Harness controller side.
    modport slave (
        input  mmio_valid, mmio_addr, mmio_wdata, con_ready,
        output mmio_ready, con_valid, con_data
    );

endinterface

// File: rtl/tb_con_fifo.sv
// Console byte FIFO; a push into a full FIFO is taken when a pop happens the same cycle.
module tb_con_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/tb_harness_ctrl.sv
// Simulation harness controller: holds the core in reset, watches tohost,
// traps and a run timeout, drains the console, then reports the verdict.
// Optional console FIFO enabled by defining TB_HARNESS_CONSOLE_EN.
module tb_harness_ctrl
    import tb_harness_pkg::*;
#(
    parameter int unsigned       NUM_CORES      = 1,
    parameter int unsigned       RESET_CYCLES   = 4,
    parameter int unsigned       TIMEOUT_CYCLES = 25,
    parameter int unsigned       CNT_W          = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = DEF_CONSOLE_ADDR,
    parameter int unsigned       CON_DEPTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 core_reset_n,
    input  logic [NUM_CORES-1:0] trap,
    tb_harness_if.slave          bus,
    output logic                 done,
    output logic                 pass,
    output logic                 timed_out,
    output logic [EXIT_W-1:0]    exit_code,
    output logic [NUM_CORES-1:0] trap_vec,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam int unsigned HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned HOLD_LAST = (RESET_CYCLES > 1) ? RESET_CYCLES - 1 : 0;
    localparam int unsigned TO_LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_e               r_state;
    state_e               w_next_state;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [HOLD_W-1:0]    w_hold_nxt;
    logic                 r_core_reset_n;
    logic                 r_done;
    logic                 r_pass;
    logic                 w_pass_nxt;
    logic                 r_timed_out;
    logic                 w_timed_out_nxt;
    logic [EXIT_W-1:0]    r_exit_code;
    logic [EXIT_W-1:0]    w_exit_nxt;
    logic [NUM_CORES-1:0] r_trap_vec;
    logic [NUM_CORES-1:0] w_trap_vec_nxt;
    logic [CNT_W-1:0]     r_cycle_count;
    logic [CNT_W-1:0]     w_cnt_nxt;

    logic                 w_mmio_ready;
    logic                 w_xfer;
    logic                 w_tohost_wr;
    logic                 w_console_wr;
    logic                 w_hold_done;
    logic                 w_timeout;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;

    // Ready is combinational on the presented address: only console writes stall.
    assign w_mmio_ready = (r_state == RUN) &&
                          !((bus.mmio_addr == CONSOLE_ADDR) && w_fifo_full);
    assign w_xfer       = bus.mmio_valid && w_mmio_ready;
    assign w_tohost_wr  = w_xfer && (bus.mmio_addr == TOHOST_ADDR);
    assign w_console_wr = w_xfer && (bus.mmio_addr == CONSOLE_ADDR);

    assign w_hold_done  = (RESET_CYCLES <= 1) || (r_hold_cnt == HOLD_W'(HOLD_LAST));
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cycle_count == CNT_W'(TO_LAST));

    assign bus.mmio_ready = w_mmio_ready;
    assign core_reset_n   = r_core_reset_n;
    assign done           = r_done;
    assign pass           = r_pass;
    assign timed_out      = r_timed_out;
    assign exit_code      = r_exit_code;
    assign trap_vec       = r_trap_vec;
    assign cycle_count    = r_cycle_count;

`ifdef TB_HARNESS_CONSOLE_EN
    logic             w_con_pop;
    logic [CON_W-1:0] w_con_data;

    assign w_con_pop = !w_fifo_empty && bus.con_ready;

    tb_con_fifo #(
        .DEPTH (CON_DEPTH),
        .WIDTH (CON_W)
    ) u_con_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_console_wr),
        .i_wdata (bus.mmio_wdata[CON_W-1:0]),
        .i_pop   (w_con_pop),
        .o_rdata (w_con_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign bus.con_valid = !w_fifo_empty;
    assign bus.con_data  = w_con_data;
`else
    // Console writes are accepted and discarded; the stream stays idle.
    logic w_unused_con;

    assign w_unused_con  = bus.con_ready ^ w_console_wr;
    assign w_fifo_empty  = 1'b1;
    assign w_fifo_full   = 1'b0;
    assign bus.con_valid = 1'b0;
    assign bus.con_data  = '0;
`endif

    // Next-state and verdict logic; trap beats tohost beats timeout.
    always_comb begin
        w_next_state    = r_state;
        w_hold_nxt      = r_hold_cnt;
        w_pass_nxt      = r_pass;
        w_timed_out_nxt = r_timed_out;
        w_exit_nxt      = r_exit_code;
        w_trap_vec_nxt  = r_trap_vec;
        w_cnt_nxt       = r_cycle_count;

        case (r_state)
            HOLD: begin
                if (w_hold_done) begin
                    w_next_state = RUN;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                if (|trap) begin
                    w_trap_vec_nxt = trap;
                    w_pass_nxt     = 1'b0;
                    w_exit_nxt     = '0;
                    w_next_state   = DRAIN;
                end else if (w_tohost_wr) begin
                    w_pass_nxt   = (bus.mmio_wdata == PASS_CODE);
                    w_exit_nxt   = exit_of(bus.mmio_wdata);
                    w_next_state = DRAIN;
                end else if (w_timeout) begin
                    w_timed_out_nxt = 1'b1;
                    w_pass_nxt      = 1'b0;
                    w_next_state    = DRAIN;
                end else if (r_cycle_count != '1) begin
                    w_cnt_nxt = r_cycle_count + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (w_fifo_empty) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = DONE;
            end
            default: begin
                w_next_state = HOLD;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= HOLD;
            r_hold_cnt     <= '0;
            r_core_reset_n <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_timed_out    <= 1'b0;
            r_exit_code    <= '0;
            r_trap_vec     <= '0;
            r_cycle_count  <= '0;
        end else begin
            r_state        <= w_next_state;
            r_hold_cnt     <= w_hold_nxt;
            r_core_reset_n <= (w_next_state == RUN);
            r_done         <= (w_next_state == DONE);
            r_pass         <= w_pass_nxt;
            r_timed_out    <= w_timed_out_nxt;
            r_exit_code    <= w_exit_nxt;
            r_trap_vec     <= w_trap_vec_nxt;
            r_cycle_count  <= w_cnt_nxt;
        end
    end

endmodule
